// File: rtl/nx_msg_arbiter.sv
// Round-robin merge of the four directional inbound streams into one
// registered, direction-tagged stream for the message decoder.
module nx_msg_arbiter #(
    parameter int STREAM_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic [STREAM_WIDTH-1:0] north_data_i,
    input  logic                    north_valid_i,
    output logic                    north_ready_o,

    input  logic [STREAM_WIDTH-1:0] east_data_i,
    input  logic                    east_valid_i,
    output logic                    east_ready_o,

    input  logic [STREAM_WIDTH-1:0] south_data_i,
    input  logic                    south_valid_i,
    output logic                    south_ready_o,

    input  logic [STREAM_WIDTH-1:0] west_data_i,
    input  logic                    west_valid_i,
    output logic                    west_ready_o,

    output logic [STREAM_WIDTH-1:0] msg_data_o,
    output logic [1:0]              msg_dir_o,
    output logic                    msg_valid_o,
    input  logic                    msg_ready_i,

    output logic                    idle_o
);

    logic [3:0]              valid_vec;
    logic [1:0]              last_q;
    logic                    slot_free;
    logic                    win_any;
    logic [1:0]              win_idx;
    logic                    xfer;
    logic [3:0]              grant;
    logic [STREAM_WIDTH-1:0] win_data;

    logic [STREAM_WIDTH-1:0] data_q;
    logic [1:0]              dir_q;
    logic                    valid_q;

    assign valid_vec = {west_valid_i, south_valid_i,
                        east_valid_i, north_valid_i};

    assign slot_free = !valid_q || msg_ready_i;

    // Search starts one past the last winner and wraps, so the most
    // recently served direction is always considered last.
    always_comb begin
        win_any = 1'b0;
        win_idx = last_q;
        for (int i = 1; i <= 4; i++) begin
            if (!win_any && valid_vec[last_q + 2'(i)]) begin
                win_any = 1'b1;
                win_idx = last_q + 2'(i);
            end
        end
    end

    assign xfer  = win_any && slot_free && !rst_i;
    assign grant = xfer ? (4'b0001 << win_idx) : 4'b0000;

    assign north_ready_o = grant[0];
    assign east_ready_o  = grant[1];
    assign south_ready_o = grant[2];
    assign west_ready_o  = grant[3];

    always_comb begin
        win_data = north_data_i;
        unique case (win_idx)
            2'd0: win_data = north_data_i;
            2'd1: win_data = east_data_i;
            2'd2: win_data = south_data_i;
            2'd3: win_data = west_data_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= '0;
            dir_q   <= 2'd0;
            valid_q <= 1'b0;
            last_q  <= 2'd3;
        end else if (xfer) begin
            data_q  <= win_data;
            dir_q   <= win_idx;
            valid_q <= 1'b1;
            last_q  <= win_idx;
        end else if (msg_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign msg_data_o  = data_q;
    assign msg_dir_o   = dir_q;
    assign msg_valid_o = valid_q;

    assign idle_o = !valid_q && !(|valid_vec);

endmodule

// File: tb/tb_nx_msg_arbiter.sv
// Directed bench for nx_msg_arbiter: reset, single source, rotation,
// backpressure, pointer persistence and reset during a stall.
module tb_nx_msg_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] north_data_i, east_data_i, south_data_i, west_data_i;
    logic        north_valid_i, east_valid_i, south_valid_i, west_valid_i;
    logic        north_ready_o, east_ready_o, south_ready_o, west_ready_o;
    logic [31:0] msg_data_o;
    logic [1:0]  msg_dir_o;
    logic        msg_valid_o;
    logic        msg_ready_i;
    logic        idle_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    nx_msg_arbiter #(.STREAM_WIDTH(32)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .north_data_i  (north_data_i),
        .north_valid_i (north_valid_i),
        .north_ready_o (north_ready_o),
        .east_data_i   (east_data_i),
        .east_valid_i  (east_valid_i),
        .east_ready_o  (east_ready_o),
        .south_data_i  (south_data_i),
        .south_valid_i (south_valid_i),
        .south_ready_o (south_ready_o),
        .west_data_i   (west_data_i),
        .west_valid_i  (west_valid_i),
        .west_ready_o  (west_ready_o),
        .msg_data_o    (msg_data_o),
        .msg_dir_o     (msg_dir_o),
        .msg_valid_o   (msg_valid_o),
        .msg_ready_i   (msg_ready_i),
        .idle_o        (idle_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Readies packed as {W,S,E,N}
    function automatic logic [31:0] rdy();
        return {28'd0, west_ready_o, south_ready_o,
                east_ready_o, north_ready_o};
    endfunction

    function automatic logic [31:0] outw();
        return {msg_valid_o, 29'd0, msg_dir_o};
    endfunction

    // Advance one clock; inputs change and checks happen at negedge+1
    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        msg_ready_i = 1'b1;
        {north_valid_i, east_valid_i, south_valid_i, west_valid_i} = '0;
        north_data_i = '0; east_data_i = '0;
        south_data_i = '0; west_data_i = '0;

        // 1: reset then idle
        step();
        step();
        chk("rst_valid", {31'd0, msg_valid_o}, 32'd0);
        chk("rst_data", msg_data_o, 32'd0);
        chk("rst_dir", {30'd0, msg_dir_o}, 32'd0);
        north_valid_i = 1'b1;
        settle();
        chk("rst_ready_gated", rdy(), 32'd0);
        north_valid_i = 1'b0;
        rst_i = 1'b0;
        settle();
        chk("idle_after_rst", {31'd0, idle_o}, 32'd1);
        chk("idle_ready", rdy(), 32'd0);
        step();
        chk("idle_valid", {31'd0, msg_valid_o}, 32'd0);

        // 2: single source east
        east_valid_i = 1'b1;
        east_data_i = 32'hCAFE0001;
        settle();
        chk("single_ready", rdy(), 32'b0010);
        chk("single_idle_busy", {31'd0, idle_o}, 32'd0);
        step();
        east_valid_i = 1'b0;
        settle();
        chk("single_data", msg_data_o, 32'hCAFE0001);
        chk("single_out", outw(), 32'h8000_0001);
        step();
        chk("single_drain", {31'd0, msg_valid_o}, 32'd0);
        chk("single_hold", msg_data_o, 32'hCAFE0001);
        chk("single_idle", {31'd0, idle_o}, 32'd1);

        // 3: all four valid, rotation from a fresh pointer
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        north_data_i = 32'h10; east_data_i = 32'h11;
        south_data_i = 32'h12; west_data_i = 32'h13;
        {north_valid_i, east_valid_i, south_valid_i, west_valid_i} = 4'hF;
        settle();
        chk("rr_first_ready", rdy(), 32'b0001);
        step();
        chk("rr0_data", msg_data_o, 32'h10);
        chk("rr0_out", outw(), 32'h8000_0000);
        chk("rr1_ready", rdy(), 32'b0010);
        step();
        chk("rr1_data", msg_data_o, 32'h11);
        chk("rr1_out", outw(), 32'h8000_0001);
        step();
        chk("rr2_data", msg_data_o, 32'h12);
        chk("rr2_out", outw(), 32'h8000_0002);
        step();
        chk("rr3_data", msg_data_o, 32'h13);
        chk("rr3_out", outw(), 32'h8000_0003);
        step();
        chk("rr4_data", msg_data_o, 32'h10);
        chk("rr4_out", outw(), 32'h8000_0000);
        {north_valid_i, east_valid_i, south_valid_i, west_valid_i} = '0;
        step();
        chk("rr_drain", {31'd0, msg_valid_o}, 32'd0);

        // 4: backpressure (pointer at north)
        north_valid_i = 1'b1;
        north_data_i = 32'hA0;
        settle();
        chk("bp_n_ready", rdy(), 32'b0001);
        step();
        north_valid_i = 1'b0;
        south_valid_i = 1'b1;
        south_data_i = 32'hA2;
        msg_ready_i = 1'b0;
        settle();
        chk("bp_first_out", outw(), 32'h8000_0000);
        for (int i = 0; i < 5; i++) begin
            chk("bp_stall_ready", rdy(), 32'd0);
            chk("bp_stall_data", msg_data_o, 32'hA0);
            chk("bp_stall_out", outw(), 32'h8000_0000);
            step();
        end
        msg_ready_i = 1'b1;
        settle();
        chk("bp_release_ready", rdy(), 32'b0100);
        step();
        south_valid_i = 1'b0;
        settle();
        chk("bp_s_data", msg_data_o, 32'hA2);
        chk("bp_s_out", outw(), 32'h8000_0002);
        step();
        chk("bp_drain", {31'd0, msg_valid_o}, 32'd0);

        // 5: pointer persistence across idle cycles
        west_valid_i = 1'b1;
        west_data_i = 32'hB3;
        settle();
        chk("pp_w_ready", rdy(), 32'b1000);
        step();
        west_valid_i = 1'b0;
        settle();
        chk("pp_w_out", outw(), 32'h8000_0003);
        step();
        step();
        step();
        chk("pp_idle", {31'd0, idle_o}, 32'd1);
        east_valid_i = 1'b1; east_data_i = 32'hB1;
        north_valid_i = 1'b1; north_data_i = 32'hB0;
        settle();
        chk("pp_n_first_ready", rdy(), 32'b0001);
        step();
        north_valid_i = 1'b0;
        settle();
        chk("pp_n_out", outw(), 32'h8000_0000);
        chk("pp_n_data", msg_data_o, 32'hB0);
        chk("pp_e_ready", rdy(), 32'b0010);
        step();
        east_valid_i = 1'b0;
        settle();
        chk("pp_e_out", outw(), 32'h8000_0001);
        chk("pp_e_data", msg_data_o, 32'hB1);
        step();

        // 6: reset during a stall
        north_valid_i = 1'b1;
        north_data_i = 32'hDEAD;
        step();
        north_valid_i = 1'b0;
        msg_ready_i = 1'b0;
        settle();
        chk("rs_held_data", msg_data_o, 32'hDEAD);
        step();
        chk("rs_held_out", outw(), 32'h8000_0000);
        rst_i = 1'b1;
        east_valid_i = 1'b1; east_data_i = 32'hE1;
        settle();
        chk("rs_ready_gated", rdy(), 32'd0);
        step();
        rst_i = 1'b0;
        settle();
        chk("rs_discard", {31'd0, msg_valid_o}, 32'd0);
        north_valid_i = 1'b1; north_data_i = 32'hE0;
        settle();
        chk("rs_n_first_ready", rdy(), 32'b0001);
        step();
        north_valid_i = 1'b0;
        msg_ready_i = 1'b1;
        settle();
        chk("rs_n_out", outw(), 32'h8000_0000);
        chk("rs_n_data", msg_data_o, 32'hE0);
        step();
        east_valid_i = 1'b0;
        settle();
        chk("rs_e_out", outw(), 32'h8000_0001);
        chk("rs_e_data", msg_data_o, 32'hE1);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
